// File: rtl/syscall_gate_pkg.sv
// syscall_gate_pkg: shared types and vector-table constants for the
// SYSCALL/SYSRET gate.
//   gate_op_t    : request opcode from decode
//   gate_fault_t : illegal-request cause reported with fault_o
//   gate_state_t : sequencer states
// Optional feature macro: SYSCALL_GATE_VECTOR_EN (vectored entry points).
// PRIV_ROUTINE_START normally comes from the shared definitions; a fallback
// is provided so this slice builds stand-alone.
`ifndef PRIV_ROUTINE_START
`define PRIV_ROUTINE_START 64'h0000_0000_0000_8000
`endif
`ifndef GATE_VEC_SHIFT
`define GATE_VEC_SHIFT 6
`endif
`ifndef GATE_VEC_COUNT
`define GATE_VEC_COUNT 16
`endif

package syscall_gate_pkg;

  typedef enum logic {
    SYSCALL = 1'b0,
    SYSRET  = 1'b1
  } gate_op_t;

  typedef enum logic [1:0] {
    NESTED   = 2'd0,
    NOT_PRIV = 2'd1,
    NO_RET   = 2'd2,
    BAD_VEC  = 2'd3
  } gate_fault_t;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    REDIR,
    WAIT_FETCH,
    SET,
    RETIRE,
    RET_REDIR
  } gate_state_t;

  localparam int unsigned GATE_VEC_SHIFT = `GATE_VEC_SHIFT;
  localparam int unsigned GATE_VEC_COUNT = `GATE_VEC_COUNT;

endpackage

// File: rtl/syscall_gate_ret_reg.sv
// gate_ret_reg: saved return PC plus valid bit.
//   i_set : load i_pc and set the valid bit
//   i_clr : clear the valid bit (set wins if both asserted)
//   o_pc  : saved return PC
//   o_valid : a return PC is held
module gate_ret_reg #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_set,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_set) begin
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/syscall_gate.sv
// syscall_gate: privilege-transition sequencer. Accepts SYSCALL/SYSRET from
// decode and orders flush, fetch redirect, CPL-set operand and retire pulse
// toward the privilege unit. Owns the saved return PC (gate_ret_reg).
// Ports:
//   req_valid_i/req_ready_o, req_op_i, req_pc_i, req_num_i : decode request
//   cpl_i, fetch_pc_i       : current CPL and fetch PC
//   flush_o, redirect_valid_o, redirect_pc_o : pipeline control
//   priv_lhs_valid_o, priv_lhs_o, priv_retire_o : privilege-unit operand/retire
//   fault_o, fault_code_o   : illegal-request pulse (one cycle after accept)
//   busy_o                  : not IDLE
// Build option: SYSCALL_GATE_VECTOR_EN enables vectored entry + BAD_VEC.
module syscall_gate
  import syscall_gate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SET_CYCLES = 4,
  parameter int unsigned INSN_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  gate_op_t              req_op_i,
  input  logic [DATA_WIDTH-1:0] req_pc_i,
  input  logic [7:0]            req_num_i,
  output logic                  req_ready_o,
  input  logic                  cpl_i,
  input  logic [DATA_WIDTH-1:0] fetch_pc_i,
  output logic                  flush_o,
  output logic                  redirect_valid_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  priv_lhs_valid_o,
  output logic [DATA_WIDTH-1:0] priv_lhs_o,
  output logic                  priv_retire_o,
  output logic                  fault_o,
  output gate_fault_t           fault_code_o,
  output logic                  busy_o
);

  localparam int unsigned CW = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;
  localparam logic [DATA_WIDTH-1:0] START = DATA_WIDTH'(`PRIV_ROUTINE_START);

  gate_state_t           r_state, w_next_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_lhs;      // 1: SYSCALL (elevate), 0: SYSRET
  logic [DATA_WIDTH-1:0] r_tgt;
  logic [DATA_WIDTH-1:0] r_ret_pc;
  logic                  r_fault;
  gate_fault_t           r_fault_code;

  logic                  w_accept;
  logic                  w_fault;
  gate_fault_t           w_fault_code;
  logic [DATA_WIDTH-1:0] w_entry;
  logic [DATA_WIDTH-1:0] w_saved_pc;
  logic                  w_saved_valid;

  assign w_accept = req_valid_i && (r_state == IDLE);

`ifdef SYSCALL_GATE_VECTOR_EN
  assign w_entry = START + (DATA_WIDTH'(req_num_i) << GATE_VEC_SHIFT);
`else
  assign w_entry = START;
  logic w_unused_num;
  assign w_unused_num = ^req_num_i;
`endif

  always_comb begin
    w_fault      = 1'b0;
    w_fault_code = NESTED;
    if (req_op_i == SYSCALL) begin
      if (cpl_i) begin
        w_fault      = 1'b1;
        w_fault_code = NESTED;
      end
`ifdef SYSCALL_GATE_VECTOR_EN
      else if (32'(req_num_i) >= 32'(GATE_VEC_COUNT)) begin
        w_fault      = 1'b1;
        w_fault_code = BAD_VEC;
      end
`endif
    end else begin
      if (!cpl_i) begin
        w_fault      = 1'b1;
        w_fault_code = NOT_PRIV;
      end else if (!w_saved_valid) begin
        w_fault      = 1'b1;
        w_fault_code = NO_RET;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:       if (w_accept && !w_fault) w_next_state = FLUSH;
      FLUSH:      w_next_state = r_lhs ? REDIR : SET;
      REDIR:      w_next_state = WAIT_FETCH;
      WAIT_FETCH: if (fetch_pc_i >= START) w_next_state = SET;
      SET:        if (r_cnt == CW'(SET_CYCLES - 1)) w_next_state = RETIRE;
      // SYSRET lowers CPL (retire) before fetch is sent back to user code.
      RETIRE:     w_next_state = r_lhs ? IDLE : RET_REDIR;
      RET_REDIR:  w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_lhs        <= 1'b0;
      r_tgt        <= '0;
      r_ret_pc     <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= NESTED;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (r_state == SET) ? r_cnt + 1'b1 : '0;
      r_fault <= w_accept && w_fault;
      if (w_accept && w_fault) begin
        r_fault_code <= w_fault_code;
      end
      if (w_accept && !w_fault) begin
        r_lhs    <= (req_op_i == SYSCALL);
        r_tgt    <= w_entry;
        r_ret_pc <= req_pc_i + DATA_WIDTH'(INSN_BYTES);
      end
    end
  end

  gate_ret_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ret (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_set  (r_state == REDIR),
    .i_clr  (r_state == RET_REDIR),
    .i_pc   (r_ret_pc),
    .o_pc   (w_saved_pc),
    .o_valid(w_saved_valid)
  );

  always_comb begin
    req_ready_o      = (r_state == IDLE);
    busy_o           = (r_state != IDLE);
    flush_o          = (r_state == FLUSH);
    redirect_valid_o = (r_state == REDIR) || (r_state == RET_REDIR);
    redirect_pc_o    = '0;
    if (r_state == REDIR)     redirect_pc_o = r_tgt;
    if (r_state == RET_REDIR) redirect_pc_o = w_saved_pc;
    priv_lhs_valid_o = (r_state == SET) || (r_state == RETIRE);
    priv_lhs_o       = priv_lhs_valid_o ? DATA_WIDTH'(r_lhs) : '0;
    priv_retire_o    = (r_state == RETIRE);
    fault_o          = r_fault;
    fault_code_o     = r_fault_code;
  end

endmodule

// File: tb/tb_syscall_gate.sv
`ifndef PRIV_ROUTINE_START
`define PRIV_ROUTINE_START 64'h0000_0000_0000_8000
`endif

module tb_syscall_gate;
  import syscall_gate_pkg::*;

  localparam logic [63:0] START = 64'(`PRIV_ROUTINE_START);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  gate_op_t    req_op_i;
  logic [63:0] req_pc_i;
  logic [7:0]  req_num_i;
  logic        req_ready_o;
  logic        cpl_i;
  logic [63:0] fetch_pc_i;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        priv_lhs_valid_o;
  logic [63:0] priv_lhs_o;
  logic        priv_retire_o;
  logic        fault_o;
  gate_fault_t fault_code_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  syscall_gate #(.DATA_WIDTH(64), .SET_CYCLES(4), .INSN_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_pc_i(req_pc_i),
    .req_num_i(req_num_i), .req_ready_o(req_ready_o), .cpl_i(cpl_i),
    .fetch_pc_i(fetch_pc_i), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .priv_lhs_valid_o(priv_lhs_valid_o), .priv_lhs_o(priv_lhs_o),
    .priv_retire_o(priv_retire_o), .fault_o(fault_o),
    .fault_code_o(fault_code_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bundle of the single-bit outputs: {ready,busy,flush,redir,lhs_v,retire,fault}
  function automatic logic [6:0] flags();
    return {req_ready_o, busy_o, flush_o, redirect_valid_o,
            priv_lhs_valid_o, priv_retire_o, fault_o};
  endfunction

  task automatic request(input gate_op_t op, input logic [63:0] pc, input logic cpl,
                         input logic [7:0] num);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_pc_i    = pc;
    cpl_i       = cpl;
    req_num_i   = num;
    tick();
    req_valid_i = 1'b0;
  endtask

  int seen;

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = SYSCALL; req_pc_i = '0;
    req_num_i = '0; cpl_i = 1'b0; fetch_pc_i = START;
    tick(); tick();
    check("reset_flags", 64'(flags()), 64'(7'b1000000));
    check("reset_redir_pc", redirect_pc_o, 64'h0);
    check("reset_lhs", priv_lhs_o, 64'h0);
    rst_n = 1'b1;
    tick();

    // SYSCALL from user, fetch already at start
    check("idle_ready", 64'(req_ready_o), 64'h1);
    request(SYSCALL, 64'h1000, 1'b0, 8'd0);
    check("sc_c1_flags", 64'(flags()), 64'(7'b0110000));
    tick();
    check("sc_c2_flags", 64'(flags()), 64'(7'b0101000));
    check("sc_c2_pc", redirect_pc_o, START);
    tick();
    check("sc_c3_flags", 64'(flags()), 64'(7'b0100000));
    for (int c = 4; c <= 7; c++) begin
      tick();
      check("sc_set_flags", 64'(flags()), 64'(7'b0100100));
      check("sc_set_lhs", priv_lhs_o, 64'h1);
    end
    tick();
    check("sc_c8_flags", 64'(flags()), 64'(7'b0100110));
    check("sc_c8_lhs", priv_lhs_o, 64'h1);
    tick();
    check("sc_c9_idle", 64'(flags()), 64'(7'b1000000));

    // SYSRET back to saved PC
    request(SYSRET, 64'h0, 1'b1, 8'd0);
    check("sr_c1_flags", 64'(flags()), 64'(7'b0110000));
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("sr_set_flags", 64'(flags()), 64'(7'b0100100));
      check("sr_set_lhs", priv_lhs_o, 64'h0);
    end
    tick();
    check("sr_c6_flags", 64'(flags()), 64'(7'b0100110));
    tick();
    check("sr_c7_flags", 64'(flags()), 64'(7'b0101000));
    check("sr_c7_pc", redirect_pc_o, 64'h1004);
    tick();
    check("sr_c8_idle", 64'(flags()), 64'(7'b1000000));

    // saved-PC valid bit was cleared -> NO_RET
    request(SYSRET, 64'h0, 1'b1, 8'd0);
    check("noret_flags", 64'(flags()), 64'(7'b1000001));
    check("noret_code", 64'(fault_code_o), 64'(NO_RET));
    tick();
    check("noret_pulse_end", 64'(flags()), 64'(7'b1000000));

    // SYSCALL while supervisor -> NESTED
    request(SYSCALL, 64'h2000, 1'b1, 8'd0);
    check("nested_flags", 64'(flags()), 64'(7'b1000001));
    check("nested_code", 64'(fault_code_o), 64'(NESTED));
    tick();
    check("nested_pulse_end", 64'(flags()), 64'(7'b1000000));

    // SYSRET from user -> NOT_PRIV
    request(SYSRET, 64'h0, 1'b0, 8'd0);
    check("notpriv_flags", 64'(flags()), 64'(7'b1000001));
    check("notpriv_code", 64'(fault_code_o), 64'(NOT_PRIV));
    tick();

    // fetch held below start
    fetch_pc_i = START - 64'h4;
    request(SYSCALL, 64'h3000, 1'b0, 8'd0);
    tick(); // c2 redirect
    for (int c = 0; c < 10; c++) begin
      tick();
      check("wait_flags", 64'(flags()), 64'(7'b0100000));
    end
    fetch_pc_i = START;
    tick();
    check("wait_exit_set", 64'(flags()), 64'(7'b0100100));
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (priv_retire_o) seen = 1;
    end
    check("wait_retire_seen", 64'(seen), 64'h1);
    tick();
    check("wait_back_idle", 64'(req_ready_o), 64'h1);

    // reset during SET aborts immediately; saved PC cleared too
    request(SYSCALL, 64'h4000, 1'b0, 8'd0);
    tick(); tick(); tick();
    check("rst_in_set", 64'(flags()), 64'(7'b0100100));
    rst_n = 1'b0;
    #1;
    check("rst_abort_flags", 64'(flags()), 64'(7'b1000000));
    check("rst_abort_lhs", priv_lhs_o, 64'h0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (priv_retire_o || priv_lhs_valid_o) seen++;
    end
    check("rst_no_retire", 64'(seen), 64'h0);
    request(SYSRET, 64'h0, 1'b1, 8'd0);
    check("rst_cleared_saved", 64'(fault_code_o), 64'(NO_RET));
    tick();

`ifdef SYSCALL_GATE_VECTOR_EN
    request(SYSCALL, 64'h5000, 1'b0, 8'd3);
    tick();
    check("vec3_pc", redirect_pc_o, START + 64'hC0);
    for (int c = 0; c < 8; c++) tick();
    check("vec3_idle", 64'(req_ready_o), 64'h1);
    request(SYSCALL, 64'h5000, 1'b0, 8'd16);
    check("vec16_flags", 64'(flags()), 64'(7'b1000001));
    check("vec16_code", 64'(fault_code_o), 64'(BAD_VEC));
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
